multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for core0. Supports lw, sw, R-type (add/sub/and/or) and beq.
//  Sequences one shared datapath (single ALU, single unified memory port) through
//  fetch/decode/execute/memory/writeback states.
//  Drives datapath mux selects, write enables and ALU control.
//  Talks to the unified memory through a req/ready handshake.
// PARAMETERS
//  RESET_STATE  FETCH  state entered on reset (fixed; listed for documentation only)
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  op             in   7  opcode from IR
//  func3          in   3  funct3 from IR
//  func7          in   7  funct7 from IR
//  alu_zero       in   1  ALU zero flag (current cycle)
//  mem_ready      in   1  memory accepts/completes the access this cycle
//  mem_req        out  1  memory access request
//  mem_write      out  1  access is a store (valid only with mem_req)
//  adr_src        out  1  memory address: 0=PC, 1=ALUOut reg
//  ir_write       out  1  load IR and oldPC
//  pc_write       out  1  load PC from result mux
//  reg_write      out  1  register file write enable
//  alu_src_a      out  2  00=PC, 01=oldPC, 10=rs1
//  alu_src_b      out  2  00=rs2, 01=imm, 10=const 4
//  result_src     out  2  00=ALUOut reg, 01=mem read data, 10=ALU result direct
//  alu_ctrl       out  3  000 add, 001 sub, 010 and, 011 or, 111 invalid
//  imm_src        out  2  00 I, 01 S, 10 B, 11 reserved
//  illegal_instr  out  1  one-cycle pulse: unsupported opcode seen in DECODE
// BEHAVIOUR
//  - States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, ALU_WB, BRANCH.
//  - Outputs are combinational from state. Exceptions: pc_write/ir_write in FETCH are
//    gated by mem_ready; pc_write in BRANCH is gated by alu_zero.
//  - Reset (async, rst_n=0): state=FETCH. While in reset, all outputs are 0, including
//    mem_req and every enable.
//  - Reset asserted mid-access drops mem_req immediately; any pending access is abandoned.
//  - FETCH:
//    mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
//    On mem_ready: ir_write=1, pc_write=1 -> DECODE. Otherwise hold FETCH.
//  - DECODE:
//    alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target into ALUOut).
//    Next state by op:
//      0000011 or 0100011 -> MEM_ADR
//      0110011            -> EXEC_R
//      1100011            -> BRANCH
//      other              -> illegal_instr=1, -> FETCH
//  - MEM_ADR:
//    alu_src_a=10, alu_src_b=01, add; imm_src=00 for load, 01 for store.
//    -> MEM_READ for load, MEM_WRITE for store.
//  - MEM_READ: mem_req=1, adr_src=1; hold until mem_ready -> MEM_WB.
//  - MEM_WB: result_src=01, reg_write=1 -> FETCH.
//  - MEM_WRITE: mem_req=1, mem_write=1, adr_src=1; hold until mem_ready -> FETCH.
//  - EXEC_R:
//    alu_src_a=10, alu_src_b=00. ALU decode on func3:
//      000 -> sub if func7[5]=1, else add
//      111 -> and
//      110 -> or
//      other -> 111
//    -> ALU_WB.
//  - ALU_WB: result_src=00, reg_write=1 -> FETCH.
//  - BRANCH:
//    alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=alu_zero -> FETCH.
//  - Inactive outputs are 0 in every state. alu_ctrl defaults to 000 outside ALU-using states.
//  - Minimum cycles with zero-wait memory: lw 5, sw 4, R-type 4, beq 3.
//    Each memory wait cycle adds 1.
//  - mem_req, adr_src and mem_write are stable while waiting for mem_ready.
//  - At most one access is outstanding.
// STRUCTURE
//  - core0_pkg (shared): opcode constants OP_LOAD/OP_STORE/OP_RTYPE/OP_BRANCH;
//    alu_ctrl_t enum (ADD/SUB/AND/OR/INVALID); imm_src_t; mux-select localparams.
//  - state_t enum is local to this module.
//  - One sub-module: alu_decoder (alu_op[1:0], func3, func7_5 -> alu_ctrl).
//    Combinational; reusable by the single-cycle controller.
//  - Single always_ff for the state register (async clear); one always_comb for
//    next-state and outputs.
// TESTING
//  1. rst_n=0 mid-MEM_READ with mem_req=1 -> mem_req=0 same cycle;
//     after release, state=FETCH, mem_req=1.
//  2. lw (op=0000011), mem_ready always 1 -> FETCH,DECODE,MEM_ADR,MEM_READ,MEM_WB;
//     reg_write=1 only in cycle 5, with result_src=01.
//  3. sw, mem_ready low 3 cycles in MEM_WRITE -> mem_req/mem_write/adr_src held high
//     4 cycles; reg_write never set; back to FETCH.
//  4. R-type func3=000, func7=0100000 -> alu_ctrl=001 in EXEC_R.
//     func3=110 -> 011. func3=010 -> 111. Each followed by reg_write=1 in ALU_WB.
//  5. beq: alu_zero=1 -> pc_write=1 in BRANCH; alu_zero=0 -> pc_write=0.
//     3 cycles total either way.
//  6. op=1111111 -> illegal_instr pulses once in DECODE; next cycle FETCH;
//     no reg_write or mem_write issued.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared control types for the core0 multi-cycle and single-cycle controllers:
// opcodes, ALU control encoding, immediate formats and datapath mux selects.
package multicycle_sequencer_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ALU_ADD     = 3'b000,
        ALU_SUB     = 3'b001,
        ALU_AND     = 3'b010,
        ALU_OR      = 3'b011,
        ALU_INVALID = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10,
        ALUOP_RSVD = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I    = 2'b00,
        IMM_S    = 2'b01,
        IMM_B    = 2'b10,
        IMM_RSVD = 2'b11
    } imm_src_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Unified memory port handshake between the controller and the memory.
// The controller (master) raises mem_req and holds it until mem_ready.
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_req, output mem_write, input mem_ready);
    modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_sequencer_alu_decoder.sv
// Combinational ALU control decoder, shared with the single-cycle controller.
// alu_op selects a fixed add/sub or the R-type funct3/funct7 decode.
module multicycle_sequencer_alu_decoder
    import multicycle_sequencer_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [2:0] func3_i,
    input  logic       func7_5_i,
    output alu_ctrl_t  alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        unique case (alu_op_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNC: begin
                unique case (func3_i)
                    3'b000: begin
                        if (func7_5_i) alu_ctrl_o = ALU_SUB;
                        else           alu_ctrl_o = ALU_ADD;
                    end
                    3'b111:  alu_ctrl_o = ALU_AND;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_INVALID;
                endcase
            end
            default: alu_ctrl_o = ALU_INVALID;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for core0 (lw, sw, add/sub/and/or, beq).
// Sequences a shared ALU and unified memory port; outputs decode from state.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       alu_zero,
    multicycle_sequencer_if.master mem,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_EXEC_R, S_ALU_WB, S_BRANCH
    } state_t;

    state_t    state_q, state_d;
    alu_op_t   alu_op;
    alu_ctrl_t alu_ctrl_e;
    imm_src_t  imm_e;
    logic      req, we;
    logic      unused_func7;

    assign unused_func7  = ^{func7[6], func7[4:0]};
    assign mem.mem_req   = req;
    assign mem.mem_write = we;
    assign alu_ctrl      = alu_ctrl_e;
    assign imm_src       = imm_e;

    multicycle_sequencer_alu_decoder u_alu_dec (
        .alu_op_i   (alu_op),
        .func3_i    (func3),
        .func7_5_i  (func7[5]),
        .alu_ctrl_o (alu_ctrl_e)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // rst_n also gates the outputs so nothing is driven while held in reset
    always_comb begin
        state_d       = state_q;
        req           = 1'b0;
        we            = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        imm_e         = IMM_I;
        illegal_instr = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    req        = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_e     = IMM_B;
                    if (op == OP_LOAD || op == OP_STORE) state_d = S_MEM_ADR;
                    else if (op == OP_RTYPE)            state_d = S_EXEC_R;
                    else if (op == OP_BRANCH)           state_d = S_BRANCH;
                    else begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    if (op == OP_LOAD) begin
                        state_d = S_MEM_READ;
                    end else begin
                        imm_e   = IMM_S;
                        state_d = S_MEM_WRITE;
                    end
                end
                S_MEM_READ: begin
                    req     = 1'b1;
                    adr_src = 1'b1;
                    if (mem.mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    result_src = RES_MEM;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    req     = 1'b1;
                    we      = 1'b1;
                    adr_src = 1'b1;
                    if (mem.mem_ready) state_d = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_FUNC;
                    state_d   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    result_src = RES_ALUOUT;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_SUB;
                    pc_write  = alu_zero;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-instruction cycle expectations
// are queued by the stimulus and checked at each falling edge by a monitor.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       alu_zero;
    logic       adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_ctrl;

    multicycle_sequencer_if mif ();

    multicycle_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .func3         (func3),
        .func7         (func7),
        .alu_zero      (alu_zero),
        .mem           (mif.master),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_ctrl      (alu_ctrl),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [6:0] n_op = '0;
    logic [2:0] n_f3 = '0;
    logic [6:0] n_f7 = '0;

    // {req, we, adr, irw, pcw, rw, srcA, srcB, res, alu, imm, illegal}
    function automatic logic [17:0] mk(
        bit req, bit we, bit adr, bit irw, bit pcw, bit rw,
        logic [1:0] a, logic [1:0] b, logic [1:0] res,
        logic [2:0] alu, logic [1:0] imm, bit ill);
        return {req, we, adr, irw, pcw, rw, a, b, res, alu, imm, ill};
    endfunction

    function automatic logic [2:0] r_alu(logic [2:0] f3, logic [6:0] f7);
        if (f3 == 3'd0) return f7[5] ? 3'd1 : 3'd0;
        if (f3 == 3'd7) return 3'd2;
        if (f3 == 3'd6) return 3'd3;
        return 3'd7;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input bit rv, input bit rdy, input bit z,
                       input logic [17:0] e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = rv;
        mif.mem_ready = rdy;
        alu_zero      = z;
        op            = n_op;
        func3         = n_f3;
        func7         = n_f7;
        x.v   = e;
        x.tag = tag;
        sbq.push_back(x);
    endtask

    // kind: 0 lw, 1 sw, 2 R-type, 3 beq, 4 unsupported opcode
    task automatic run_instr(input int kind, input logic [6:0] bad_op,
                             input logic [2:0] f3, input logic [6:0] f7,
                             input bit z, input int wf, input int wm,
                             input bit abort);
        logic [17:0] rd_v, wr_v;
        rd_v = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0);
        wr_v = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0);
        unique case (kind)
            0:       n_op = 7'b0000011;
            1:       n_op = 7'b0100011;
            2:       n_op = 7'b0110011;
            3:       n_op = 7'b1100011;
            default: n_op = bad_op;
        endcase
        n_f3 = f3;
        n_f7 = f7;
        for (int i = 0; i < wf; i++)
            cyc(1, 0, rb(), mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'd0, 2'b00, 0),
                "fetch_wait");
        cyc(1, 1, rb(), mk(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 3'd0, 2'b00, 0), "fetch");
        cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'd0, 2'b10, kind == 4),
            "decode");
        if (kind == 0) begin
            cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'd0, 2'b00, 0),
                "mem_adr_lw");
            for (int i = 0; i < wm; i++) cyc(1, 0, rb(), rd_v, "mem_read_wait");
            if (abort) begin
                cyc(0, 1, rb(), '0, "reset_mid_read");
                cyc(0, rb(), rb(), '0, "reset_hold");
                return;
            end
            cyc(1, 1, rb(), rd_v, "mem_read");
            cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'd0, 2'b00, 0),
                "mem_wb");
        end else if (kind == 1) begin
            cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'd0, 2'b01, 0),
                "mem_adr_sw");
            for (int i = 0; i < wm; i++) cyc(1, 0, rb(), wr_v, "mem_write_wait");
            cyc(1, 1, rb(), wr_v, "mem_write");
        end else if (kind == 2) begin
            cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, r_alu(f3, f7), 2'b00, 0),
                "exec_r");
            cyc(1, rb(), rb(), mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 0),
                "alu_wb");
        end else if (kind == 3) begin
            cyc(1, rb(), z, mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 3'd1, 2'b00, 0),
                "branch");
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t        e;
            logic [17:0] act;
            e   = sbq.pop_front();
            act = {mif.mem_req, mif.mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_ctrl, imm_src, illegal_instr};
            n_vec++;
            if (act !== e.v) begin
                n_err++;
                $display("FAIL %s @%0t: got %b expected %b", e.tag, $time, act, e.v);
            end
        end
    end

    initial begin
        logic [6:0] bop;
        int         k;
        rst_n         = 1'b0;
        mif.mem_ready = 1'b0;
        alu_zero      = 1'b0;
        op            = '0;
        func3         = '0;
        func7         = '0;
        repeat (3) cyc(0, rb(), rb(), '0, "reset");

        run_instr(0, 7'h0, 3'd0, 7'h00, 0, 0, 0, 0);
        run_instr(1, 7'h0, 3'd0, 7'h00, 0, 0, 3, 0);
        run_instr(2, 7'h0, 3'b000, 7'b0100000, 0, 0, 0, 0);
        run_instr(2, 7'h0, 3'b110, 7'h00, 0, 0, 0, 0);
        run_instr(2, 7'h0, 3'b010, 7'h00, 0, 0, 0, 0);
        run_instr(2, 7'h0, 3'b000, 7'h00, 0, 1, 0, 0);
        run_instr(2, 7'h0, 3'b111, 7'h00, 0, 0, 0, 0);
        run_instr(3, 7'h0, 3'd0, 7'h00, 1, 0, 0, 0);
        run_instr(3, 7'h0, 3'd0, 7'h00, 0, 0, 0, 0);
        run_instr(4, 7'h7F, 3'd0, 7'h00, 0, 0, 0, 0);
        run_instr(0, 7'h0, 3'd0, 7'h00, 0, 0, 2, 1);
        run_instr(0, 7'h0, 3'd0, 7'h00, 0, 2, 1, 0);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 4);
            do bop = 7'($urandom);
            while (bop == 7'b0000011 || bop == 7'b0100011 ||
                   bop == 7'b0110011 || bop == 7'b1100011);
            run_instr(k, bop, 3'($urandom), 7'($urandom), rb(),
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      k == 0 && $urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
